// File: rtl/dmaster_tadt_pkg.sv
// Shared constants and width helpers for the debug-master RL0 -> RL1 timing adapter.
package dmaster_tadt_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;

  // Width able to hold every occupancy value 0..depth inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a FIFO index; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmaster_rl1_timing_adt_if.sv
// Byte-stream bus for the timing adapter: RL0 upstream side and RL1 downstream side.
// The slave modport is the adapter itself; the master modport drives it.
interface dmaster_rl1_timing_adt_if
  import dmaster_tadt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dmaster_tadt_fifo_mem.sv
// Storage for the timing adapter FIFO: unreset register array with a single write
// port and a registered read port (the read register is the output data register).
module dmaster_tadt_fifo_mem
  import dmaster_tadt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Array write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read; holds the last popped byte when no read occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/dmaster_rl1_timing_adt.sv
// Avalon-ST timing adapter, ready latency 0 upstream to ready latency 1 downstream,
// for the debug master return byte stream. A small FIFO absorbs bytes in flight
// while the sink backpressures. All handshake outputs come straight from flops.
// Optional feature: define DMASTER_TADT_LEVEL_STATS_EN to add the max_level
// occupancy high-water-mark output.
module dmaster_rl1_timing_adt
  import dmaster_tadt_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input logic                       clk,
  input logic                       reset_n,
  dmaster_rl1_timing_adt_if.slave   bus
`ifdef DMASTER_TADT_LEVEL_STATS_EN
  ,
  output logic [lvl_w(DEPTH)-1:0]   max_level
`endif
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned LvlW = lvl_w(DEPTH);
  localparam logic [LvlW-1:0] DepthL = LvlW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] count_q, count_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            push, pop;

  // Pop is decided on this cycle's out_ready; the beat shows up next cycle (RL1).
  assign push = bus.in_valid && in_ready_q;
  assign pop  = bus.out_ready && (count_q != '0);

  // Occupancy next state; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LvlW'(1);
      2'b01:   count_d = count_q - LvlW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and registered handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      // in_ready stays low during reset and rises on the first edge after release.
      in_ready_q  <= (count_d < DepthL);
      out_valid_q <= pop;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  dmaster_tadt_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.in_data),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (bus.out_data)
  );

`ifdef DMASTER_TADT_LEVEL_STATS_EN
  logic [LvlW-1:0] max_level_q;

  // Sticky high-water mark of occupancy, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_level_q <= '0;
    end else if (count_d > max_level_q) begin
      max_level_q <= count_d;
    end
  end

  assign max_level = max_level_q;
`endif

`ifndef SYNTHESIS
  int unsigned stall_q;

  // Simulation-only: count consecutive cycles of upstream valid blocked by in_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= 0;
    end else if (bus.in_valid && !in_ready_q) begin
      stall_q <= stall_q + 1;
    end else begin
      stall_q <= 0;
    end
  end

  // Simulation-only: flag a possible upstream stall.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (stall_q <= DEPTH)
        else $warning("possible upstream stall: in_valid blocked for %0d cycles", stall_q);
    end
  end
`endif

endmodule

// File: tb/tb_dmaster_rl1_timing_adt.sv
// Self-checking bench for dmaster_rl1_timing_adt: directed scenarios followed by a
// randomized run, all compared each cycle against a queue-based behavioural model.
module tb_dmaster_rl1_timing_adt;
  import dmaster_tadt_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmaster_rl1_timing_adt_if #(.DATA_W(DW)) bus ();

`ifdef DMASTER_TADT_LEVEL_STATS_EN
  logic [lvl_w(DEPTH)-1:0] max_level;
`endif

  dmaster_rl1_timing_adt #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus)
`ifdef DMASTER_TADT_LEVEL_STATS_EN
    ,
    .max_level (max_level)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall = 0;

  // Reference model: plain FIFO queue plus the expected registered outputs.
  logic [7:0] q[$];
  bit         m_rdy;
  bit         m_ov;
  logic [7:0] m_od;
  int         m_max;

  logic [7:0] got[$];
  int         beat_cyc[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy = 1'b0;
    m_ov  = 1'b0;
    m_od  = 8'h00;
    m_max = 0;
  endtask

  // One clock: predict from the inputs at the edge, then compare 1 time unit later.
  task automatic tick();
    bit         do_push;
    bit         do_pop;
    bit         prev_ordy;
    logic [7:0] din;
    do_push   = bus.in_valid && m_rdy;
    do_pop    = bus.out_ready && (q.size() > 0);
    prev_ordy = bus.out_ready;
    din       = bus.in_data;
    if (bus.in_valid && !m_rdy) stall++;
    else stall = 0;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset_n) begin
      model_reset();
    end else begin
      if (do_pop) begin
        m_od = q.pop_front();
        m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
      if (do_push) q.push_back(din);
      m_rdy = (q.size() < DEPTH);
      if (q.size() > m_max) m_max = q.size();
    end
    chk("in_ready", bus.in_ready, m_rdy);
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_data", bus.out_data, m_od);
`ifdef DMASTER_TADT_LEVEL_STATS_EN
    chk("max_level", max_level, m_max);
`endif
    if (bus.out_valid === 1'b1) begin
      chk("rl1_prev_ready", prev_ordy, 1);
      got.push_back(bus.out_data);
      beat_cyc.push_back(cyc);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a byte until the model says it was taken, within a cycle budget.
  task automatic send(input logic [7:0] d, input int budget);
    bit done;
    bit acc;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < budget && !done; i++) begin
      acc = m_rdy;
      tick();
      done = acc;
    end
    chk("send_accept", done, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(tag, got[i], exp_q[i]);
  endtask

  task automatic clear_log();
    got.delete();
    beat_cyc.delete();
  endtask

  initial begin
    int present_cyc;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    model_reset();

    // Reset state.
    ticks(2);
    reset_n = 1'b1;
    #1;
    chk("rdy_before_first_edge", bus.in_ready, 0);
    tick();

    // Back-to-back stream with the sink always ready: two-cycle latency, no gaps.
    bus.out_ready = 1'b1;
    clear_log();
    present_cyc = cyc;
    send(8'h11, 4);
    send(8'h22, 4);
    send(8'h33, 4);
    ticks(4);
    exp_q = '{8'h11, 8'h22, 8'h33};
    chk_got("stream3");
    if (beat_cyc.size() == 3) begin
      chk("first_beat_latency", beat_cyc[0] - present_cyc, 2);
      chk("beats_back_to_back", beat_cyc[2] - beat_cyc[0], 2);
    end

    // Backpressure: only DEPTH bytes fit, then drain in order.
    bus.out_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 4);
    chk("full_blocks_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA4;
    tick();
    chk("still_full", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    send(8'hA4, 8);
    send(8'hA5, 8);
    ticks(8);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    chk_got("backpressure");

    // Toggled out_ready: beats only follow cycles where out_ready was high.
    bus.out_ready = 1'b0;
    clear_log();
    send(8'h5A, 4);
    send(8'hC3, 4);
    tick();
    chk("no_beat_while_held", got.size(), 0);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0; tick();
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0; tick();
    ticks(2);
    exp_q = '{8'h5A, 8'hC3};
    chk_got("toggle");

    // Full FIFO with simultaneous pop and push attempt: push blocked, reopens next cycle.
    clear_log();
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 4);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hEE;
    tick();
    chk("reopen_after_pop", bus.in_ready, 1);
    send(8'hEE, 4);
    ticks(8);
    exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hEE};
    chk_got("full_pop_push");

    // Reset mid-stream with bytes queued: outputs drop at once, nothing stale afterwards.
    bus.out_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 4);
    bus.out_ready = 1'b1;
    tick();
    chk("beat_before_reset", bus.out_valid, 1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_out_data", bus.out_data, 0);
    ticks(2);
    reset_n = 1'b1;
    clear_log();
    ticks(6);
    chk("no_stale_after_reset", got.size(), 0);

`ifdef DMASTER_TADT_LEVEL_STATS_EN
    // High-water mark is sticky after draining.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'hD0 + 8'(i), 4);
    bus.out_ready = 1'b1;
    ticks(6);
    chk("max_level_sticky", max_level, 3);
`endif

    // Randomized traffic; upstream backs off after two blocked cycles.
    clear_log();
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = (stall >= 2) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    ticks(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
